term_mem_ctrl: RTL and testbench

//  Parametrised successor to the terminal's data/video memory pair. Decodes one CPU port across a data RAM and a video RAM.

---
 rtl/term_mem_pkg.sv | 29 ++
 rtl/tdp_ram.sv | 51 +++++
 rtl/term_mem_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_term_mem_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/term_mem_pkg.sv
// Shared types for the terminal memory controller: engine states, CPU address
// regions and a constant-width helper.
package term_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_SC_RD = 3'd2,
    ST_SC_WR = 3'd3,
    ST_FILL  = 3'd4,
    ST_FIN   = 3'd5
  } eng_state_e;

  typedef enum logic [1:0] {
    RG_DMEM = 2'd0,
    RG_VMEM = 2'd1,
    RG_NONE = 2'd2
  } region_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tdp_ram.sv
// Single-clock RAM: write/read port A plus independent read port B, both
// synchronous and read-first. Only the output registers are reset.
module tdp_ram
  import term_mem_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 256,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_en,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [W-1:0]  a_wdata,
  output logic [W-1:0]  a_rdata,
  input  logic          b_en,
  input  logic [AW-1:0] b_addr,
  output logic [W-1:0]  b_rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rd_a_d, rd_a_q;
  logic [W-1:0] rd_b_d, rd_b_q;

  always_ff @(posedge clk) begin
    if (a_en && a_we) mem[a_addr] <= a_wdata;
  end

  // Reads sample the array before this edge's write lands, giving read-first.
  always_comb begin
    rd_a_d = rd_a_q;
    rd_b_d = rd_b_q;
    if (a_en && !a_we) rd_a_d = mem[a_addr];
    if (b_en)          rd_b_d = mem[b_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

  assign a_rdata = rd_a_q;
  assign b_rdata = rd_b_q;

endmodule

// File: rtl/term_mem_ctrl.sv
// Terminal memory controller: CPU port decoded over data and video RAM, a
// free-running VGA scan port, and a clear/scroll engine that owns video port A.
module term_mem_ctrl
  import term_mem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DMEM_DEPTH = 256,
  parameter int VCOLS      = 8,
  parameter int VROWS      = 8,
  parameter int ADDR_W     = 10,
  parameter logic [DATA_W-1:0] BLANK = '0,
  localparam int VDEPTH    = VCOLS * VROWS,
  localparam int VA_W      = clog2(VDEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  input  logic [VA_W-1:0]   vga_addr,
  output logic [DATA_W-1:0] vga_data,
  input  logic              cmd_clear,
  input  logic              cmd_scroll,
  output logic              busy,
  output logic              done
);

  localparam int DA_W = clog2(DMEM_DEPTH);
  localparam logic [ADDR_W-1:0] VBASE       = ADDR_W'(DMEM_DEPTH);
  localparam logic [VA_W-1:0]   IDX_LAST    = VA_W'(VDEPTH - 1);
  localparam logic [VA_W-1:0]   IDX_SC_LAST = VA_W'(VDEPTH - VCOLS - 1);
  localparam logic [VA_W-1:0]   ROW_OFS     = VA_W'(VCOLS);

  region_e           region;
  logic              cpu_acc;
  logic [VA_W-1:0]   voff;

  eng_state_e        state_d, state_q;
  logic [VA_W-1:0]   idx_d, idx_q;
  logic              busy_d, busy_q;
  logic              done_d, done_q;

  logic              rvalid_d, rvalid_q;
  logic              err_d, err_q;
  region_e           rsel_d, rsel_q;

  logic              va_en, va_we;
  logic [VA_W-1:0]   va_addr;
  logic [DATA_W-1:0] va_wdata;
  logic [DATA_W-1:0] vmem_rdata_a;
  logic [DATA_W-1:0] dmem_rdata;
  logic [DATA_W-1:0] dmem_b_unused;

  always_comb begin
    if (int'(cpu_addr) < DMEM_DEPTH)               region = RG_DMEM;
    else if (int'(cpu_addr) < DMEM_DEPTH + VDEPTH) region = RG_VMEM;
    else                                           region = RG_NONE;
  end

  assign voff      = VA_W'(cpu_addr - VBASE);
  // Only video accesses wait for the engine; data RAM stays on its own port.
  assign cpu_ready = !(busy_q && (region == RG_VMEM));
  assign cpu_acc   = cpu_req && cpu_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (cmd_clear) begin
          state_d = ST_CLR;
          idx_d   = '0;
          busy_d  = 1'b1;
        end else if (cmd_scroll) begin
          state_d = ST_SC_RD;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_CLR, ST_FILL: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = ST_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_SC_RD: state_d = ST_SC_WR;
      ST_SC_WR: begin
        idx_d   = idx_q + 1'b1;
        state_d = (idx_q == IDX_SC_LAST) ? ST_FILL : ST_SC_RD;
      end
      ST_FIN: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Video port A: engine while it runs, CPU otherwise (including the FIN cycle).
  always_comb begin
    va_en    = 1'b0;
    va_we    = 1'b0;
    va_addr  = voff;
    va_wdata = cpu_wdata;
    case (state_q)
      ST_CLR, ST_FILL: begin
        va_en    = 1'b1;
        va_we    = 1'b1;
        va_addr  = idx_q;
        va_wdata = BLANK;
      end
      ST_SC_RD: begin
        va_en   = 1'b1;
        va_addr = idx_q + ROW_OFS;
      end
      ST_SC_WR: begin
        va_en    = 1'b1;
        va_we    = 1'b1;
        va_addr  = idx_q;
        va_wdata = vmem_rdata_a;
      end
      default: begin
        va_en = cpu_acc && (region == RG_VMEM);
        va_we = cpu_we;
      end
    endcase
  end

  always_comb begin
    rvalid_d = cpu_acc && !cpu_we;
    err_d    = cpu_acc && (region == RG_NONE);
    rsel_d   = rvalid_d ? region : rsel_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rsel_q   <= RG_NONE;
    end else begin
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rsel_q   <= rsel_d;
    end
  end

  always_comb begin
    case (rsel_q)
      RG_DMEM: cpu_rdata = dmem_rdata;
      RG_VMEM: cpu_rdata = vmem_rdata_a;
      default: cpu_rdata = '0;
    endcase
  end

  tdp_ram #(.W(DATA_W), .DEPTH(DMEM_DEPTH)) u_dmem (
    .clk     (clk),
    .rst     (rst),
    .a_en    (cpu_acc && (region == RG_DMEM)),
    .a_we    (cpu_we),
    .a_addr  (cpu_addr[DA_W-1:0]),
    .a_wdata (cpu_wdata),
    .a_rdata (dmem_rdata),
    .b_en    (1'b0),
    .b_addr  ({DA_W{1'b0}}),
    .b_rdata (dmem_b_unused)
  );

  tdp_ram #(.W(DATA_W), .DEPTH(VDEPTH)) u_vmem (
    .clk     (clk),
    .rst     (rst),
    .a_en    (va_en),
    .a_we    (va_we),
    .a_addr  (va_addr),
    .a_wdata (va_wdata),
    .a_rdata (vmem_rdata_a),
    .b_en    (1'b1),
    .b_addr  (vga_addr),
    .b_rdata (vga_data)
  );

  assign cpu_rvalid = rvalid_q;
  assign cpu_err    = err_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_term_mem_ctrl.sv
// Randomised bench for term_mem_ctrl with a word-level memory/engine model and
// directed checks of the clear, scroll, stall and reset scenarios.
module tb_term_mem_ctrl;

  localparam int DM  = 256;
  localparam int VC  = 8;
  localparam int VD  = 64;
  localparam int AW  = 10;
  localparam int VAW = 6;
  localparam int SC_CYC = 2 * (VD - VC) + VC;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [31:0]   cpu_wdata = '0;
  logic          cpu_ready, cpu_rvalid, cpu_err;
  logic [31:0]   cpu_rdata, vga_data;
  logic [VAW-1:0] vga_addr = '0;
  logic          cmd_clear = 1'b0;
  logic          cmd_scroll = 1'b0;
  logic          busy, done;

  always #5 clk = ~clk;

  term_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .vga_addr(vga_addr), .vga_data(vga_data),
    .cmd_clear(cmd_clear), .cmd_scroll(cmd_scroll), .busy(busy), .done(done)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model: plain word arrays plus an engine cycle counter.
  logic [31:0] dm_m [DM];
  logic [31:0] vm_m [VD];
  bit   mem_ok = 1'b0;
  bit   eng_busy = 1'b0, eng_fin = 1'b0, eng_clr = 1'b0;
  int   eng_t = 0;
  logic exp_rvalid = 1'b0, exp_err = 1'b0, exp_done = 1'b0;
  logic [31:0] exp_rdata = '0, exp_vga = '0;
  int   m_a, m_rg, m_i;
  bit   m_acc, m_idle;

  function automatic int region_of(input logic [AW-1:0] a);
    int v;
    v = int'(a);
    if (v < DM) return 0;
    if (v < DM + VD) return 1;
    return 2;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_busy = 0; eng_fin = 0;
      exp_rvalid = 0; exp_err = 0; exp_done = 0; exp_rdata = '0; exp_vga = '0;
    end else begin
      m_a    = int'(cpu_addr);
      m_rg   = region_of(cpu_addr);
      m_idle = !eng_busy && !eng_fin;
      m_acc  = cpu_req && !(eng_busy && m_rg == 1);
      exp_vga    = vm_m[vga_addr];
      exp_rvalid = m_acc && !cpu_we;
      exp_err    = m_acc && (m_rg == 2);
      if (m_acc && !cpu_we)
        exp_rdata = (m_rg == 0) ? dm_m[cpu_addr[7:0]] : (m_rg == 1) ? vm_m[VAW'(m_a - DM)] : 32'h0;
      if (m_acc && cpu_we) begin
        if (m_rg == 0) dm_m[cpu_addr[7:0]] = cpu_wdata;
        else if (m_rg == 1) vm_m[VAW'(m_a - DM)] = cpu_wdata;
      end
      exp_done = 0;
      if (eng_fin) eng_fin = 0;
      else if (eng_busy) begin
        if (eng_clr) vm_m[VAW'(eng_t)] = 32'h0;
        else if (eng_t < 2 * (VD - VC)) begin
          if (eng_t % 2 == 1) begin
            m_i = (eng_t - 1) / 2;
            vm_m[VAW'(m_i)] = vm_m[VAW'(m_i + VC)];
          end
        end else vm_m[VAW'(VD - VC + eng_t - 2 * (VD - VC))] = 32'h0;
        eng_t++;
        if (eng_t == (eng_clr ? VD : SC_CYC)) begin
          eng_busy = 0; eng_fin = 1; exp_done = 1;
        end
      end else if (m_idle && (cmd_clear || cmd_scroll)) begin
        eng_busy = 1; eng_clr = cmd_clear; eng_t = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("rvalid", 32'(cpu_rvalid), 32'(exp_rvalid));
    if (exp_rvalid) chk("rdata", cpu_rdata, exp_rdata);
    chk("err", 32'(cpu_err), 32'(exp_err));
    chk("busy", 32'(busy), 32'(eng_busy));
    chk("done", 32'(done), 32'(exp_done));
    chk("ready", 32'(cpu_ready), 32'(!(eng_busy && region_of(cpu_addr) == 1)));
    if (mem_ok) chk("vga", vga_data, exp_vga);
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic cpu_wr(input int a, input logic [31:0] d);
    cpu_req = 1; cpu_we = 1; cpu_addr = AW'(a); cpu_wdata = d;
    step();
    cpu_req = 0; cpu_we = 0;
  endtask

  task automatic cpu_rd(input int a, output logic [31:0] d, output logic v, output logic e);
    cpu_req = 1; cpu_we = 0; cpu_addr = AW'(a);
    step();
    cpu_req = 0;
    d = cpu_rdata; v = cpu_rvalid; e = cpu_err;
  endtask

  task automatic run_cmd(input logic clr, input logic scr, output int n);
    cmd_clear = clr; cmd_scroll = scr;
    step();
    cmd_clear = 0; cmd_scroll = 0;
    n = 1;
    while (!done && n < 400) begin
      step();
      n++;
    end
  endtask

  task automatic load_video(input int base);
    for (int i = 0; i < VD; i++) cpu_wr(DM + i, 32'(base + i));
  endtask

  logic [31:0] d;
  logic v, e;
  int   n;
  bit   saw_done;

  initial begin
    rst = 1;
    repeat (3) step();
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_vga", vga_data, 32'h0);
    rst = 0;
    for (int i = 0; i < DM; i++) cpu_wr(i, $urandom);
    load_video(0);
    step();
    mem_ok = 1;

    cpu_wr(5, 32'hDEADBEEF);
    cpu_rd(5, d, v, e);
    chk("t1_rdata", d, 32'hDEADBEEF);
    chk("t1_rvalid", 32'(v), 32'h1);
    cpu_wr(DM + 3, 32'hDEADBEEF);
    vga_addr = 6'd3;
    step();
    chk("t1_vga", vga_data, 32'hDEADBEEF);

    cpu_rd(DM + VD, d, v, e);
    chk("t2_rdata", d, 32'h0);
    chk("t2_rvalid", 32'(v), 32'h1);
    chk("t2_err", 32'(e), 32'h1);
    cpu_wr(DM + VD, 32'h12345678);
    cpu_rd(DM + VD, d, v, e);
    chk("t2_rd_again", d, 32'h0);

    load_video(0);
    run_cmd(1'b0, 1'b1, n);
    chk("t3_cycles", 32'(n), 32'd121);
    cpu_rd(DM + 0, d, v, e);  chk("t3_w0", d, 32'd8);
    cpu_rd(DM + 55, d, v, e); chk("t3_w55", d, 32'd63);
    cpu_rd(DM + 56, d, v, e); chk("t3_w56", d, 32'h0);
    cpu_rd(DM + 63, d, v, e); chk("t3_w63", d, 32'h0);

    load_video(100);
    run_cmd(1'b1, 1'b1, n);
    chk("t4_cycles", 32'(n), 32'd65);
    cpu_rd(DM + 0, d, v, e);  chk("t4_w0", d, 32'h0);
    cpu_rd(DM + 37, d, v, e); chk("t4_w37", d, 32'h0);
    cpu_rd(DM + 63, d, v, e); chk("t4_w63", d, 32'h0);

    cmd_clear = 1;
    step();
    cmd_clear = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = AW'(7);
    #1 chk("t5_dmem_ready", 32'(cpu_ready), 32'h1);
    step();
    cpu_we = 1; cpu_addr = AW'(DM + 9); cpu_wdata = 32'h55AA55AA;
    #1 chk("t5_vmem_stall", 32'(cpu_ready), 32'h0);
    n = 0;
    while (!cpu_ready && n < 200) begin
      step();
      vga_addr = VAW'($urandom_range(0, VD - 1));
      #1 n++;
    end
    chk("t5_stall_bounded", 32'(n < 200), 32'h1);
    chk("t5_fin_done", 32'(done), 32'h1);
    step();
    cpu_req = 0; cpu_we = 0;
    cpu_rd(DM + 9, d, v, e);  chk("t5_w9", d, 32'h55AA55AA);
    cpu_rd(DM + 10, d, v, e); chk("t5_w10", d, 32'h0);

    load_video(0);
    cmd_scroll = 1;
    step();
    cmd_scroll = 0;
    repeat (40) step();
    #1 rst = 1;
    #1 chk("t6_busy", 32'(busy), 32'h0);
    step();
    rst = 0;
    saw_done = 0;
    for (int i = 0; i < 130; i++) begin
      step();
      saw_done |= done;
    end
    chk("t6_no_done", 32'(saw_done), 32'h0);
    run_cmd(1'b1, 1'b0, n);
    chk("t6_clear_cycles", 32'(n), 32'd65);

    for (int i = 0; i < 3000; i++) begin
      cpu_req    = ($urandom_range(0, 1) == 1);
      cpu_we     = ($urandom_range(0, 1) == 1);
      cpu_addr   = AW'($urandom_range(0, DM + VD + 15));
      cpu_wdata  = $urandom;
      vga_addr   = VAW'($urandom_range(0, VD - 1));
      cmd_clear  = ($urandom_range(0, 199) == 0);
      cmd_scroll = ($urandom_range(0, 149) == 0);
      step();
    end
    cpu_req = 0; cpu_we = 0; cmd_clear = 0; cmd_scroll = 0;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
